// File: rtl/rv_bus_arbiter.sv
// Two-requester arbiter sharing one single-beat Wishbone-style port between fetch and LSU.
// Optional fetch starvation guard: define RV_BUS_ARB_STARVE_GUARD_EN.
module rv_bus_arbiter #(
   parameter int IADDR_SPACE_BITS = 16,
   parameter int DADDR_SPACE_BITS = 32,
   parameter int STARVE_LIMIT     = 4
) (
   input  logic                        i_clk,
   input  logic                        i_reset_n,
   input  logic [IADDR_SPACE_BITS-1:0] i_fetch_addr,
   input  logic                        i_fetch_cyc,
   output logic [31:0]                 o_fetch_rdata,
   output logic                        o_fetch_ack,
   input  logic [DADDR_SPACE_BITS-1:0] i_data_addr,
   input  logic [31:0]                 i_data_wdata,
   input  logic [3:0]                  i_data_sel,
   input  logic                        i_data_we,
   input  logic                        i_data_cyc,
   output logic [31:0]                 o_data_rdata,
   output logic                        o_data_ack,
   output logic [31:0]                 o_bus_addr,
   output logic [31:0]                 o_bus_wdata,
   output logic [3:0]                  o_bus_sel,
   output logic                        o_bus_we,
   output logic                        o_bus_cyc,
   input  logic [31:0]                 i_bus_rdata,
   input  logic                        i_bus_ack,
   output logic                        o_grant_data
);

   typedef enum logic [1:0] {IDLE, GNT_I, GNT_D} state_t;

   state_t state, state_nxt;
   logic   decide;
   logic   starve_hit;
   logic   grant_d;
   logic   grant_i;

   if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_limit
      $error("rv_bus_arbiter: STARVE_LIMIT must be in 1..15");
   end

   // Data wins ties unless fetch has been passed over STARVE_LIMIT times in a row.
   assign grant_d = i_data_cyc && !(i_fetch_cyc && starve_hit);
   assign grant_i = i_fetch_cyc && !grant_d;

`ifdef RV_BUS_ARB_STARVE_GUARD_EN
   localparam logic [3:0] STARVE_LIM4 = 4'(STARVE_LIMIT);

   logic [3:0] starve_cnt, starve_cnt_nxt;

   assign starve_hit = (starve_cnt == STARVE_LIM4);

   always_comb begin
      starve_cnt_nxt = starve_cnt;
      if (decide) begin
         if (!i_fetch_cyc || grant_i) starve_cnt_nxt = 4'd0;
         else if (grant_d)            starve_cnt_nxt = starve_cnt + 4'd1;
      end
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) starve_cnt <= 4'd0;
      else            starve_cnt <= starve_cnt_nxt;
   end
`else
   assign starve_hit = 1'b0;
`endif

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) state <= IDLE;
      else            state <= state_nxt;
   end

   // A dropped owner cyc aborts the transfer; an ack re-arbitrates in the same edge.
   always_comb begin
      state_nxt = state;
      decide    = 1'b0;
      case (state)
         IDLE:  decide = 1'b1;
         GNT_I: begin
            if (!i_fetch_cyc)   state_nxt = IDLE;
            else if (i_bus_ack) decide    = 1'b1;
         end
         GNT_D: begin
            if (!i_data_cyc)    state_nxt = IDLE;
            else if (i_bus_ack) decide    = 1'b1;
         end
         default: state_nxt = IDLE;
      endcase
      if (decide) begin
         if (grant_d)      state_nxt = GNT_D;
         else if (grant_i) state_nxt = GNT_I;
         else              state_nxt = IDLE;
      end
   end

   always_comb begin
      o_bus_cyc     = 1'b0;
      o_bus_addr    = 32'h0;
      o_bus_wdata   = 32'h0;
      o_bus_sel     = 4'h0;
      o_bus_we      = 1'b0;
      o_fetch_ack   = 1'b0;
      o_data_ack    = 1'b0;
      o_fetch_rdata = 32'h0;
      o_data_rdata  = 32'h0;
      o_grant_data  = 1'b0;
      case (state)
         GNT_I: begin
            o_bus_cyc   = i_fetch_cyc;
            o_bus_addr  = 32'(i_fetch_addr);
            o_bus_sel   = 4'hF;
            o_fetch_ack = i_fetch_cyc & i_bus_ack;
         end
         GNT_D: begin
            o_bus_cyc    = i_data_cyc;
            o_bus_addr   = 32'(i_data_addr);
            o_bus_wdata  = i_data_wdata;
            o_bus_sel    = i_data_sel;
            o_bus_we     = i_data_we;
            o_data_ack   = i_data_cyc & i_bus_ack;
            o_grant_data = 1'b1;
         end
         default: ;
      endcase
      o_fetch_rdata = o_fetch_ack ? i_bus_rdata : 32'h0;
      o_data_rdata  = o_data_ack  ? i_bus_rdata : 32'h0;
   end

endmodule

// File: tb/tb_rv_bus_arbiter.sv
// Self-checking bench for rv_bus_arbiter: vector table, directed corner sequences, random vs reference model.
module tb_rv_bus_arbiter;

   localparam int LIMIT = 4;
`ifdef RV_BUS_ARB_STARVE_GUARD_EN
   localparam bit GUARD = 1'b1;
`else
   localparam bit GUARD = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        i_reset_n;
   logic [15:0] i_fetch_addr;
   logic        i_fetch_cyc;
   logic [31:0] o_fetch_rdata;
   logic        o_fetch_ack;
   logic [31:0] i_data_addr;
   logic [31:0] i_data_wdata;
   logic [3:0]  i_data_sel;
   logic        i_data_we;
   logic        i_data_cyc;
   logic [31:0] o_data_rdata;
   logic        o_data_ack;
   logic [31:0] o_bus_addr;
   logic [31:0] o_bus_wdata;
   logic [3:0]  o_bus_sel;
   logic        o_bus_we;
   logic        o_bus_cyc;
   logic [31:0] i_bus_rdata;
   logic        i_bus_ack;
   logic        o_grant_data;

   always #5 clk = ~clk;

   rv_bus_arbiter #(.IADDR_SPACE_BITS(16), .DADDR_SPACE_BITS(32), .STARVE_LIMIT(LIMIT)) dut (
      .i_clk(clk), .i_reset_n(i_reset_n),
      .i_fetch_addr(i_fetch_addr), .i_fetch_cyc(i_fetch_cyc),
      .o_fetch_rdata(o_fetch_rdata), .o_fetch_ack(o_fetch_ack),
      .i_data_addr(i_data_addr), .i_data_wdata(i_data_wdata), .i_data_sel(i_data_sel),
      .i_data_we(i_data_we), .i_data_cyc(i_data_cyc),
      .o_data_rdata(o_data_rdata), .o_data_ack(o_data_ack),
      .o_bus_addr(o_bus_addr), .o_bus_wdata(o_bus_wdata), .o_bus_sel(o_bus_sel),
      .o_bus_we(o_bus_we), .o_bus_cyc(o_bus_cyc),
      .i_bus_rdata(i_bus_rdata), .i_bus_ack(i_bus_ack), .o_grant_data(o_grant_data)
   );

   int n_chk  = 0;
   int n_pass = 0;

   function automatic logic [136:0] pack(input logic cyc, input logic [31:0] addr,
         input logic [31:0] wd, input logic [3:0] sel, input logic we,
         input logic fa, input logic [31:0] fr, input logic da, input logic [31:0] dr,
         input logic gd);
      return {cyc, addr, wd, sel, we, fa, fr, da, dr, gd};
   endfunction

   function automatic logic [136:0] outvec();
      return pack(o_bus_cyc, o_bus_addr, o_bus_wdata, o_bus_sel, o_bus_we,
                  o_fetch_ack, o_fetch_rdata, o_data_ack, o_data_rdata, o_grant_data);
   endfunction

   task automatic chk(input string name, input logic [136:0] act, input logic [136:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic clear_inputs();
      i_fetch_cyc = 0; i_fetch_addr = '0; i_data_cyc = 0; i_data_addr = '0;
      i_data_wdata = '0; i_data_sel = '0; i_data_we = 0; i_bus_ack = 0; i_bus_rdata = '0;
   endtask

   // Reset with every request and ack active; outputs must stay zero regardless.
   task automatic do_reset();
      @(negedge clk);
      i_reset_n = 0;
      i_fetch_cyc = 1; i_fetch_addr = 16'h1234; i_data_cyc = 1; i_data_addr = 32'h5678;
      i_data_we = 1; i_data_sel = 4'hF; i_data_wdata = 32'hFFFF_FFFF;
      i_bus_ack = 1; i_bus_rdata = 32'hCAFE_F00D;
      #1 chk("reset_outputs", outvec(), '0);
      @(negedge clk);
      clear_inputs();
      i_reset_n = 1;
   endtask

   typedef struct {
      logic        fcyc;
      logic [15:0] faddr;
      logic        back;
      logic [31:0] brdata;
      logic [136:0] exp;
   } vec_t;

   vec_t tv[8];

   function automatic vec_t mkv(input logic fcyc, input logic [15:0] faddr, input logic back,
                                input logic [31:0] brdata, input logic [136:0] exp);
      vec_t v;
      v.fcyc = fcyc; v.faddr = faddr; v.back = back; v.brdata = brdata; v.exp = exp;
      return v;
   endfunction

   // Reference model: who owns the bus and how many times fetch has been passed over.
   int m_own;      // 0 = nobody, 1 = fetch, 2 = data
   int m_starve;

   task automatic model_eval(output logic [136:0] e, output logic efa, output logic eda);
      logic owner_req;
      logic fetch_first;
      efa = 0; eda = 0; e = '0;
      if (m_own == 1) begin
         efa = i_fetch_cyc & i_bus_ack;
         e = pack(i_fetch_cyc, {16'h0, i_fetch_addr}, 32'h0, 4'hF, 1'b0,
                  efa, efa ? i_bus_rdata : 32'h0, 1'b0, 32'h0, 1'b0);
      end else if (m_own == 2) begin
         eda = i_data_cyc & i_bus_ack;
         e = pack(i_data_cyc, i_data_addr, i_data_wdata, i_data_sel, i_data_we,
                  1'b0, 32'h0, eda, eda ? i_bus_rdata : 32'h0, 1'b1);
      end
      owner_req = (m_own == 1) ? i_fetch_cyc : i_data_cyc;
      if (m_own != 0 && !owner_req) begin
         m_own = 0;
      end else if (m_own == 0 || efa || eda) begin
         fetch_first = GUARD && i_fetch_cyc && i_data_cyc && (m_starve == LIMIT);
         if (i_data_cyc && !fetch_first) begin
            m_own = 2;
            m_starve = i_fetch_cyc ? m_starve + 1 : 0;
         end else if (i_fetch_cyc) begin
            m_own = 1; m_starve = 0;
         end else begin
            m_own = 0; m_starve = 0;
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [136:0] e;
      logic efa, eda, pfa, pda, found;
      bit   rec[10];
      int   nrec;

      i_reset_n = 1;
      clear_inputs();
      do_reset();

      // Fetch read with ack two cycles after grant, then a spurious ack while idle.
      tv[0] = mkv(1, 16'h0010, 0, 32'h0, '0);
      tv[1] = mkv(1, 16'h0010, 0, 32'h0, pack(1, 32'h10, 0, 4'hF, 0, 0, 0, 0, 0, 0));
      tv[2] = mkv(1, 16'h0010, 0, 32'h0, pack(1, 32'h10, 0, 4'hF, 0, 0, 0, 0, 0, 0));
      tv[3] = mkv(1, 16'h0010, 1, 32'h13, pack(1, 32'h10, 0, 4'hF, 0, 1, 32'h13, 0, 0, 0));
      tv[4] = mkv(0, 16'h0000, 0, 32'h0, pack(0, 32'h0, 0, 4'hF, 0, 0, 0, 0, 0, 0));
      tv[5] = mkv(0, 16'h0000, 0, 32'h0, '0);
      tv[6] = mkv(0, 16'h0000, 1, 32'hAAAA5555, '0);
      tv[7] = mkv(0, 16'h0000, 0, 32'h0, '0);
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         i_fetch_cyc = tv[k].fcyc; i_fetch_addr = tv[k].faddr;
         i_bus_ack = tv[k].back; i_bus_rdata = tv[k].brdata;
         #1 chk($sformatf("vec%0d", k), outvec(), tv[k].exp);
      end

      // Simultaneous requests: data write first, fetch follows once data is done.
      @(negedge clk);
      clear_inputs();
      i_fetch_cyc = 1; i_fetch_addr = 16'h0020;
      i_data_cyc = 1; i_data_addr = 32'h2000_0004; i_data_wdata = 32'hDEADBEEF;
      i_data_sel = 4'h3; i_data_we = 1;
      #1 chk("both_req_idle", outvec(), '0);
      @(negedge clk);
      #1 chk("data_first", outvec(), pack(1, 32'h2000_0004, 32'hDEADBEEF, 4'h3, 1, 0, 0, 0, 0, 1));
      @(negedge clk);
      i_bus_ack = 1; i_bus_rdata = 32'h1234_5678;
      #1 chk("data_ack", outvec(),
             pack(1, 32'h2000_0004, 32'hDEADBEEF, 4'h3, 1, 0, 0, 1, 32'h1234_5678, 1));
      @(negedge clk);
      i_data_cyc = 0; i_bus_ack = 0;
      found = 0;
      for (int i = 0; i < 6 && !found; i++) begin
         #1;
         if (o_bus_cyc && !o_grant_data) found = 1;
         else @(negedge clk);
      end
      chk("fetch_after_data", {found, o_bus_addr, o_bus_sel, o_bus_we}, {1'b1, 32'h20, 4'hF, 1'b0});
      i_bus_ack = 1; i_bus_rdata = 32'h0000_0093;
      #1 chk("fetch_ack_after_data", outvec(), pack(1, 32'h20, 0, 4'hF, 0, 1, 32'h93, 0, 0, 0));
      @(negedge clk);
      clear_inputs();
      repeat (2) @(negedge clk);

      // Abort: owner drops cyc after one granted cycle, ack arrives late.
      i_data_cyc = 1; i_data_addr = 32'h100; i_data_sel = 4'hF;
      @(negedge clk);
      #1 chk("abort_grant", outvec(), pack(1, 32'h100, 0, 4'hF, 0, 0, 0, 0, 0, 1));
      @(negedge clk);
      i_data_cyc = 0;
      #1 chk("abort_drop", {o_bus_cyc, o_data_ack, o_fetch_ack}, 3'b000);
      @(negedge clk);
      i_bus_ack = 1; i_bus_rdata = 32'h7777_7777;
      #1 chk("abort_late_ack", outvec(), '0);
      @(negedge clk);
      clear_inputs();
      #1 chk("abort_idle", outvec(), '0);

      // Asynchronous reset in the middle of a fetch transfer.
      @(negedge clk);
      i_fetch_cyc = 1; i_fetch_addr = 16'h0040;
      @(negedge clk);
      #1 chk("rst_pre", outvec(), pack(1, 32'h40, 0, 4'hF, 0, 0, 0, 0, 0, 0));
      #2 i_reset_n = 0;
      #1 chk("rst_async", outvec(), '0);
      @(negedge clk);
      i_reset_n = 1; i_fetch_cyc = 0; i_bus_ack = 1; i_bus_rdata = 32'h0BAD_0BAD;
      #1 chk("rst_no_ack", outvec(), '0);
      @(negedge clk);
      i_bus_ack = 0;
      #1 chk("rst_after", outvec(), '0);

      // Starvation: both request continuously, slave acks every bus cycle.
      do_reset();
      i_fetch_cyc = 1; i_fetch_addr = 16'h0080;
      i_data_cyc = 1; i_data_addr = 32'h300; i_data_sel = 4'hF;
      nrec = 0;
      for (int c = 0; c < 60 && nrec < 10; c++) begin
         @(negedge clk);
         i_bus_ack = o_bus_cyc; i_bus_rdata = c;
         #1;
         if (o_data_ack)       begin rec[nrec] = 0; nrec++; end
         else if (o_fetch_ack) begin rec[nrec] = 1; nrec++; end
      end
      chk("starve_transfers", nrec, 10);
      for (int k = 0; k < 10; k++)
         chk($sformatf("starve_grant%0d", k), rec[k], (GUARD && (k % 5 == 4)) ? 1'b1 : 1'b0);
      @(negedge clk);
      clear_inputs();

      // Random traffic against the reference model.
      do_reset();
      m_own = 0; m_starve = 0; pfa = 0; pda = 0;
      for (int c = 0; c < 500; c++) begin
         @(negedge clk);
         if (i_fetch_cyc) begin
            if (pfa) begin
               if ($urandom % 2) i_fetch_addr = 16'($urandom);
               else i_fetch_cyc = 0;
            end else if ($urandom % 32 == 0) i_fetch_cyc = 0;
         end else if ($urandom % 5 < 2) begin
            i_fetch_cyc = 1; i_fetch_addr = 16'($urandom);
         end
         if (i_data_cyc) begin
            if (pda) begin
               if ($urandom % 2) begin
                  i_data_addr = $urandom; i_data_wdata = $urandom;
                  i_data_sel = 4'($urandom); i_data_we = 1'($urandom);
               end else i_data_cyc = 0;
            end else if ($urandom % 32 == 0) i_data_cyc = 0;
         end else if ($urandom % 5 < 2) begin
            i_data_cyc = 1; i_data_addr = $urandom; i_data_wdata = $urandom;
            i_data_sel = 4'($urandom); i_data_we = 1'($urandom);
         end
         i_bus_ack = ($urandom % 3 == 0);
         i_bus_rdata = $urandom;
         #1;
         model_eval(e, efa, eda);
         chk($sformatf("rand%0d", c), outvec(), e);
         pfa = efa; pda = eda;
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
